// File: rtl/riscv_mem_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mem_pkg
// Shared definitions for the memory-stage Avalon master:
//   - funct3 access-size/sign codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - mem_state_t, the transaction FSM state type (one-hot encoded)
//   - small helpers that classify a funct3/offset pair as legal/aligned
// ---------------------------------------------------------------------------
package riscv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // One-hot so that each Avalon command strobe is a direct decode of a
   // single state flop and cannot glitch.
   typedef enum logic [4:0] {
      IDLE    = 5'b00001,
      RD_REQ  = 5'b00010,
      RD_WAIT = 5'b00100,
      WR_REQ  = 5'b01000,
      DONE    = 5'b10000
   } mem_state_t;

   // funct3 codes 011, 110 and 111 have no meaning for this stage.
   function automatic logic isLegalFunct3(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // Halfwords must sit on an even byte, words on a multiple of four.
   function automatic logic isAligned(input logic [2:0] f3, input logic [1:0] offset);
      logic ok;
      case (f3)
         F3_H, F3_HU: ok = ~offset[0];
         F3_W:        ok = (offset == 2'b00);
         default:     ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_stage_avalon_master_if.sv
// ---------------------------------------------------------------------------
// mem_stage_avalon_master_if
// Avalon-MM data-memory port between the memory stage and the data memory.
//   avm_address        byte address, always word aligned
//   avm_read/avm_write command strobes
//   avm_byteenable     active byte lanes
//   avm_writedata      lane-replicated store data
//   avm_readdata       load data from the slave
//   avm_waitrequest    slave is not accepting the current command
//   avm_readdatavalid  avm_readdata carries returned load data
// Modports: master (memory stage side) and slave (memory side).
// ---------------------------------------------------------------------------
interface mem_stage_avalon_master_if #(
   parameter int ADDR_W = 32
);

   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_write;
   logic [3:0]        avm_byteenable;
   logic [31:0]       avm_writedata;
   logic [31:0]       avm_readdata;
   logic              avm_waitrequest;
   logic              avm_readdatavalid;

   modport master (
      output avm_address,
      output avm_read,
      output avm_write,
      output avm_byteenable,
      output avm_writedata,
      input  avm_readdata,
      input  avm_waitrequest,
      input  avm_readdatavalid
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      input  avm_write,
      input  avm_byteenable,
      input  avm_writedata,
      output avm_readdata,
      output avm_waitrequest,
      output avm_readdatavalid
   );

endinterface

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for the memory stage.
// Request side (live EX/MEM values):
//   reqFunct3, reqOffset, storeData -> byteEnable, writeData, accessOk
// Response side (values captured when the load was issued):
//   capFunct3, capOffset, rawReadData -> loadData (sign/zero extended)
// ---------------------------------------------------------------------------
module mem_lane_align
   import riscv_mem_pkg::*;
(
   input  logic [2:0]  reqFunct3,
   input  logic [1:0]  reqOffset,
   input  logic [31:0] storeData,
   output logic [3:0]  byteEnable,
   output logic [31:0] writeData,
   output logic        accessOk,

   input  logic [2:0]  capFunct3,
   input  logic [1:0]  capOffset,
   input  logic [31:0] rawReadData,
   output logic [31:0] loadData
);

   logic [7:0]  byteLane;
   logic [15:0] halfLane;

   // Store side: the memory only looks at the enabled lanes, so the
   // store value is replicated into every lane instead of shifted.
   always_comb begin
      byteEnable = 4'b0000;
      writeData  = storeData;
      accessOk   = isLegalFunct3(reqFunct3) & isAligned(reqFunct3, reqOffset);
      case (reqFunct3)
         F3_B, F3_BU: begin
            byteEnable = 4'b0001 << reqOffset;
            writeData  = {4{storeData[7:0]}};
         end
         F3_H, F3_HU: begin
            byteEnable = reqOffset[1] ? 4'b1100 : 4'b0011;
            writeData  = {2{storeData[15:0]}};
         end
         F3_W: begin
            byteEnable = 4'b1111;
            writeData  = storeData;
         end
         default: begin
            byteEnable = 4'b0000;
            writeData  = storeData;
         end
      endcase
   end

   // Load side: pick the addressed lane out of the returned word, using the
   // offset and size captured at issue time because the pipeline inputs may
   // not be trustworthy by the time data returns.
   always_comb begin
      byteLane = rawReadData[{capOffset, 3'b000} +: 8];
      halfLane = capOffset[1] ? rawReadData[31:16] : rawReadData[15:0];
      case (capFunct3)
         F3_B:    loadData = {{24{byteLane[7]}}, byteLane};
         F3_BU:   loadData = {24'h000000, byteLane};
         F3_H:    loadData = {{16{halfLane[15]}}, halfLane};
         F3_HU:   loadData = {16'h0000, halfLane};
         default: loadData = rawReadData;
      endcase
   end

endmodule

// File: rtl/mem_stage_avalon_master.sv
// ---------------------------------------------------------------------------
// mem_stage_avalon_master
// Memory-stage bus master. Turns EX/MEM load/store requests into single
// Avalon-MM transactions and stalls the pipeline until each one finishes.
// Ports:
//   CLK, RST_n        clock, asynchronous active-low reset
//   MemRead/MemWrite  request levels from EX/MEM, held while Stall is high
//   funct3            access size and sign
//   AluRes            effective byte address
//   Reg2              store data
//   Stall             hold EX/MEM and earlier stages
//   ReadData          extended load result, updated when a load completes
//   AccErr            one-cycle pulse for a misaligned or illegal access
//   bus               Avalon-MM master port
// ---------------------------------------------------------------------------
module mem_stage_avalon_master
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic        CLK,
   input  logic        RST_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] AluRes,
   input  logic [31:0] Reg2,
   output logic        Stall,
   output logic [31:0] ReadData,
   output logic        AccErr,
   mem_stage_avalon_master_if.master bus
);

   mem_state_t  state;
   mem_state_t  nextState;

   logic        reqAny;
   logic        reqLegal;
   logic        reqErr;
   logic        accessOk;
   logic        loadDone;
   logic [3:0]  laneBe;
   logic [31:0] laneWd;
   logic [31:0] loadData;
   logic [2:0]  capFunct3;
   logic [1:0]  capOffset;

   // A request is only issued to the bus when exactly one of read/write is
   // asked for and the size/offset combination is legal; everything else
   // goes straight to DONE with an error pulse.
   assign reqAny   = MemRead | MemWrite;
   assign reqLegal = (MemRead ^ MemWrite) & accessOk;
   assign reqErr   = reqAny & ~reqLegal;

   // Returned data can arrive in the accepting RD_REQ cycle or later in RD_WAIT.
   assign loadDone = bus.avm_readdatavalid &
                     (((state == RD_REQ) & ~bus.avm_waitrequest) | (state == RD_WAIT));

   mem_lane_align uLaneAlign (
      .reqFunct3   (funct3),
      .reqOffset   (AluRes[1:0]),
      .storeData   (Reg2),
      .byteEnable  (laneBe),
      .writeData   (laneWd),
      .accessOk    (accessOk),
      .capFunct3   (capFunct3),
      .capOffset   (capOffset),
      .rawReadData (bus.avm_readdata),
      .loadData    (loadData)
   );

   // State register.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. DONE always returns to IDLE so that the pipeline
   // advance at the end of DONE is never mistaken for a new request.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (reqLegal) begin
               nextState = MemRead ? RD_REQ : WR_REQ;
            end else if (reqErr) begin
               nextState = DONE;
            end
         end
         RD_REQ: begin
            if (!bus.avm_waitrequest) begin
               nextState = bus.avm_readdatavalid ? DONE : RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (bus.avm_readdatavalid) begin
               nextState = DONE;
            end
         end
         WR_REQ: begin
            if (!bus.avm_waitrequest) begin
               nextState = DONE;
            end
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Output decode. Stall is combinational from the request inputs only in
   // IDLE, so a request is held from its very first cycle; DONE is the single
   // cycle in which the pipeline is allowed to move.
   always_comb begin
      Stall         = 1'b0;
      bus.avm_read  = 1'b0;
      bus.avm_write = 1'b0;
      case (state)
         IDLE:    Stall = reqAny;
         RD_REQ: begin
            Stall        = 1'b1;
            bus.avm_read = 1'b1;
         end
         RD_WAIT: Stall = 1'b1;
         WR_REQ: begin
            Stall         = 1'b1;
            bus.avm_write = 1'b1;
         end
         default: Stall = 1'b0;
      endcase
   end

   // Command and result registers. Command fields are loaded only when a
   // transaction is launched from IDLE, which keeps them stable for the whole
   // time the slave holds waitrequest.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         bus.avm_address    <= '0;
         bus.avm_byteenable <= 4'b0000;
         bus.avm_writedata  <= 32'h0000_0000;
         capFunct3          <= 3'b000;
         capOffset          <= 2'b00;
         ReadData           <= 32'h0000_0000;
         AccErr             <= 1'b0;
      end else begin
         AccErr <= (state == IDLE) & reqErr;
         if ((state == IDLE) && reqLegal) begin
            bus.avm_address    <= {AluRes[ADDR_W-1:2], 2'b00};
            bus.avm_byteenable <= laneBe;
            bus.avm_writedata  <= laneWd;
            capFunct3          <= funct3;
            capOffset          <= AluRes[1:0];
         end
         if (loadDone) begin
            ReadData <= loadData;
         end
      end
   end

endmodule

// File: doc/mem_stage_avalon_master.md
# mem_stage_avalon_master

Memory-stage bus master that consumes the EX/MEM pipeline register outputs and turns load/store requests into Avalon-MM transactions on the data memory port. Generates byte enables and lane-aligned write data, extracts and sign/zero-extends load data, and stalls the pipeline until each transaction completes. Sits between the EX/MEM register and the MEM/WB register.

## Interface
- ADDR_W, 32, Avalon byte-address width; word-aligned address is driven
- CLK  in  1  clock
- RST_n  in  1  asynchronous active-low reset
- MemRead  in  1  load request from EX/MEM (level, held while stalled)
- MemWrite  in  1  store request from EX/MEM (level, held while stalled)
- funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- AluRes  in  32  effective byte address
- Reg2  in  32  store data (low bytes significant)
- Stall  out  1  hold EX/MEM and earlier stages; Enable of pipe regs = !Stall
- ReadData  out  32  extended load result, valid from DONE until the next load completes
- AccErr  out  1  one-cycle pulse in DONE for misaligned/illegal access
- avm_address  out  ADDR_W  {AluRes[ADDR_W-1:2],2'b00}
- avm_read, avm_write  out  1  Avalon command strobes
- avm_byteenable  out  4  lane enables
- avm_writedata  out  32  lane-replicated store data
- avm_readdata  in  32  Avalon read data
- avm_waitrequest  in  1  slave not accepting command
- avm_readdatavalid  in  1  read data returned (pipelined read)

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE; encoding in package.
- IDLE: MemRead xor MemWrite with legal aligned funct3/address -> RD_REQ or WR_REQ; capture address, byteenable, writedata, funct3, addr[1:0]. Illegal/misaligned, or MemRead&MemWrite both high -> DONE with AccErr, no bus access. Neither -> stay.
- RD_REQ: avm_read=1; waitrequest=0 -> RD_WAIT (readdatavalid in same cycle -> DONE directly).
- RD_WAIT: avm_read=0; readdatavalid=1 -> latch extracted data into ReadData, -> DONE. No timeout.
- WR_REQ: avm_write=1; waitrequest=0 -> DONE.
- DONE: Stall=0 for exactly this cycle, pipeline advances at its closing edge; request inputs ignored; -> IDLE.
- Stall = (IDLE & (MemRead|MemWrite)) | RD_REQ | RD_WAIT | WR_REQ.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00; funct3 011/110/111 illegal.
- Byteenable: byte 0001<<addr[1:0]; half addr[1]? 1100:0011; word 1111.
- Writedata: byte {4{Reg2[7:0]}}, half {2{Reg2[15:0]}}, word Reg2.
- Load extract: select byte/half lane by captured addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- Command outputs (address, byteenable, writedata) held stable while waitrequest=1.
- Reset (any time, incl. mid-transaction): state IDLE, avm_read=avm_write=0, avm_address=0, byteenable=0, writedata=0, ReadData=0, AccErr=0; Stall then follows inputs combinationally.

## Timing
- Command strobes and command data are registered; ReadData and AccErr registered.
- Store, zero wait: cycle0 IDLE (Stall=1), cycle1 WR_REQ write=1, cycle2 DONE (Stall=0): 3 cycles.
- Load, zero wait, readdatavalid one cycle after acceptance: IDLE, RD_REQ, RD_WAIT, DONE: 4 cycles.
- Each waitrequest cycle adds one cycle; each readdatavalid delay cycle adds one.
- Error: IDLE, DONE: 2 cycles.
- Stall is combinational from MemRead/MemWrite only in IDLE.

## Structure
- Package riscv_mem_pkg: funct3 localparams (F3_B/H/W/BU/HU), state enum mem_state_t.
- Sub-module mem_lane_align (combinational): byteenable, writedata replication, load extract, alignment check.

## Test plan
- SW AluRes=0x104, Reg2=0xDEADBEEF, waitrequest=0 -> address 0x104, be 1111, writedata 0xDEADBEEF, Stall high 2 cycles.
- SB AluRes=0x103, Reg2=0x000000A5, waitrequest high 3 cycles -> be 1000, writedata 0xA5A5A5A5 stable, Stall high 5 cycles.
- LB AluRes=0x202, readdata 0x80FF7F00, valid 2 cycles after accept -> ReadData 0xFFFFFFFF; LBU same -> 0x000000FF; LH at 0x202 -> 0xFFFF80FF.
- LW AluRes=0x301 -> no avm_read, AccErr pulse, Stall 1 cycle; MemRead&MemWrite both high -> same.
- RST_n low during RD_WAIT -> avm_read=0, state IDLE, ReadData 0 immediately; next load completes normally.
- Back-to-back SW then LW with no bubble -> second request starts in IDLE cycle after DONE, no dropped or duplicated access.
